// File: rtl/sb_hazard_unit.sv
// sb_hazard_unit: scoreboard RAW stall / bypass-select unit tracking per-register writer age and result latency.
// Defining SB_HAZARD_STATS_EN adds the stall_cnt / byp_cnt performance counters.
module sb_hazard_unit #(
    parameter int NREGS = 32,
    parameter int NBYP  = 3,
    parameter int AW    = $clog2(NREGS),
    parameter int BSW   = $clog2(NBYP + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           val_D,
    input  logic           rs1_en_D,
    input  logic [AW-1:0]  rs1_D,
    input  logic           rs2_en_D,
    input  logic [AW-1:0]  rs2_D,
    input  logic           rd_wen_D,
    input  logic [AW-1:0]  rd_D,
    input  logic [BSW-1:0] lat_D,
    input  logic           squash_D,
    input  logic           freeze,
    output logic           stall_D,
    output logic [BSW-1:0] op1_byp_sel_D,
    output logic [BSW-1:0] op2_byp_sel_D,
    output logic           issue_D,
    output logic           busy
`ifdef SB_HAZARD_STATS_EN
    ,
    output logic [31:0]    stall_cnt,
    output logic [31:0]    byp_cnt
`endif
);
    logic [BSW-1:0] age [NREGS];
    logic [BSW-1:0] lat [NREGS];
    logic [BSW-1:0] lat_n, age1, age2;
    logic haz1, haz2, nr1, nr2, wr;

    assign lat_n = (lat_D == '0) ? BSW'(1) : (lat_D > BSW'(NBYP)) ? BSW'(NBYP) : lat_D;
    assign age1 = age[rs1_D];
    assign age2 = age[rs2_D];
    assign haz1 = val_D & rs1_en_D & (rs1_D != '0) & (age1 != '0);
    assign haz2 = val_D & rs2_en_D & (rs2_D != '0) & (age2 != '0);
    assign nr1 = haz1 & (age1 < lat[rs1_D]);
    assign nr2 = haz2 & (age2 < lat[rs2_D]);
    assign stall_D = val_D & (nr1 | nr2);
    assign op1_byp_sel_D = (haz1 & ~stall_D) ? age1 : '0;
    assign op2_byp_sel_D = (haz2 & ~stall_D) ? age2 : '0;
    assign issue_D = val_D & ~stall_D & ~squash_D & ~freeze;
    assign wr = issue_D & rd_wen_D & (rd_D != '0);

    // x0 is never tracked: entry 0 only ever sees the reset value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                age[r] <= '0;
                lat[r] <= '0;
            end
        end else if (!freeze) begin
            for (int r = 1; r < NREGS; r++) begin
                if (wr && rd_D == AW'(r)) begin
                    age[r] <= BSW'(1);
                    lat[r] <= lat_n;
                end else if (age[r] == BSW'(NBYP)) age[r] <= '0;
                else if (age[r] != '0) age[r] <= age[r] + BSW'(1);
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int r = 1; r < NREGS; r++) busy = busy | (age[r] != '0);
    end

`ifdef SB_HAZARD_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            byp_cnt   <= '0;
        end else begin
            if (val_D & stall_D & ~squash_D & ~freeze) stall_cnt <= stall_cnt + 32'd1;
            if (issue_D & ((op1_byp_sel_D != '0) | (op2_byp_sel_D != '0))) byp_cnt <= byp_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_sb_hazard_unit.sv
// tb_sb_hazard_unit: scoreboard bench for sb_hazard_unit against a tick-based writer-record model.
module tb_sb_hazard_unit;
    localparam int NREGS = 32, NBYP = 3, AW = 5, BSW = 2;
    logic clk = 1'b0, rst = 1'b1;
    logic val_D = 0, rs1_en_D = 0, rs2_en_D = 0, rd_wen_D = 0, squash_D = 0, freeze = 0;
    logic [AW-1:0] rs1_D = '0, rs2_D = '0, rd_D = '0;
    logic [BSW-1:0] lat_D = '0;
    logic stall_D, issue_D, busy;
    logic [BSW-1:0] op1_byp_sel_D, op2_byp_sel_D;
`ifdef SB_HAZARD_STATS_EN
    logic [31:0] stall_cnt, byp_cnt;
`endif
    int errors = 0, checks = 0;

    sb_hazard_unit #(.NREGS(NREGS), .NBYP(NBYP)) dut (
        .clk(clk), .rst(rst), .val_D(val_D), .rs1_en_D(rs1_en_D), .rs1_D(rs1_D),
        .rs2_en_D(rs2_en_D), .rs2_D(rs2_D), .rd_wen_D(rd_wen_D), .rd_D(rd_D), .lat_D(lat_D),
        .squash_D(squash_D), .freeze(freeze), .stall_D(stall_D), .op1_byp_sel_D(op1_byp_sel_D),
        .op2_byp_sel_D(op2_byp_sel_D), .issue_D(issue_D), .busy(busy)
`ifdef SB_HAZARD_STATS_EN
        , .stall_cnt(stall_cnt), .byp_cnt(byp_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic stall, issue, busy;
        logic [BSW-1:0] s1, s2;
        logic [31:0] sc, bc;
    } exp_t;
    exp_t q[$];

    // Model: a writer is remembered by the unfrozen-cycle tick at which it issued.
    int tick = 0;
    int wtick [NREGS];
    int wlat [NREGS];
    bit wv [NREGS];
    int unsigned m_sc = 0, m_bc = 0;

    task automatic cmp(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic int m_age(int r);
        int a;
        if (r == 0 || !wv[r]) return 0;
        a = tick - wtick[r];
        return (a >= 1 && a <= NBYP) ? a : 0;
    endfunction

    function automatic int norm(int l);
        return (l == 0) ? 1 : (l > NBYP) ? NBYP : l;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) wv[r] = 0;
        m_sc = 0;
        m_bc = 0;
    endtask

    task automatic compute(output exp_t e);
        int a1, a2;
        bit nr1, nr2;
        a1 = (val_D && rs1_en_D) ? m_age(int'(rs1_D)) : 0;
        a2 = (val_D && rs2_en_D) ? m_age(int'(rs2_D)) : 0;
        nr1 = a1 != 0 && a1 < wlat[rs1_D];
        nr2 = a2 != 0 && a2 < wlat[rs2_D];
        e.stall = val_D && (nr1 || nr2);
        e.s1 = (a1 != 0 && !e.stall) ? BSW'(a1) : '0;
        e.s2 = (a2 != 0 && !e.stall) ? BSW'(a2) : '0;
        e.issue = val_D && !e.stall && !squash_D && !freeze;
        e.busy = 0;
        for (int r = 1; r < NREGS; r++) if (m_age(r) != 0) e.busy = 1;
        e.sc = m_sc;
        e.bc = m_bc;
    endtask

    task automatic advance(exp_t e);
        if (val_D && e.stall && !squash_D && !freeze) m_sc++;
        if (e.issue && (e.s1 != 0 || e.s2 != 0)) m_bc++;
        if (!freeze) begin
            if (e.issue && rd_wen_D && rd_D != 0) begin
                wv[rd_D] = 1;
                wtick[rd_D] = tick;
                wlat[rd_D] = norm(int'(lat_D));
            end
            tick++;
        end
    endtask

    task automatic drive(bit v, bit e1, int r1, bit e2, int r2, bit w, int rd, int l, bit sq, bit fr);
        val_D = v; rs1_en_D = e1; rs1_D = AW'(r1); rs2_en_D = e2; rs2_D = AW'(r2);
        rd_wen_D = w; rd_D = AW'(rd); lat_D = BSW'(l); squash_D = sq; freeze = fr;
    endtask

    task automatic step(bit v, bit e1, int r1, bit e2, int r2, bit w, int rd, int l, bit sq, bit fr);
        exp_t e;
        @(posedge clk);
        #1;
        drive(v, e1, r1, e2, r2, w, rd, l, sq, fr);
        compute(e);
        q.push_back(e);
        advance(e);
    endtask

    task automatic mid_reset();
        exp_t e;
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        cmp("async_rst_busy", busy, 0);
`ifdef SB_HAZARD_STATS_EN
        cmp("async_rst_stall_cnt", stall_cnt, 0);
        cmp("async_rst_byp_cnt", byp_cnt, 0);
`endif
        rst = 1'b0;
        model_reset();
        compute(e);
        q.push_back(e);
        advance(e);
    endtask

    // Monitor: outputs are valid every cycle the scoreboard holds an expectation.
    initial forever begin
        @(negedge clk);
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            cmp("stall_D", stall_D, e.stall);
            cmp("issue_D", issue_D, e.issue);
            cmp("busy", busy, e.busy);
            cmp("op1_byp_sel_D", op1_byp_sel_D, e.s1);
            cmp("op2_byp_sel_D", op2_byp_sel_D, e.s2);
`ifdef SB_HAZARD_STATS_EN
            cmp("stall_cnt", stall_cnt, e.sc);
            cmp("byp_cnt", byp_cnt, e.bc);
`endif
        end
    end

    initial begin
        model_reset();
        #2;
        cmp("reset_stall", stall_D, 0);
        cmp("reset_sel1", op1_byp_sel_D, 0);
        cmp("reset_sel2", op2_byp_sel_D, 0);
        cmp("reset_issue", issue_D, 0);
        cmp("reset_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        // ALU chain
        step(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
        step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); #1 cmp("alu_age1_sel", op1_byp_sel_D, 1);
        step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); #1 cmp("alu_age2_sel", op1_byp_sel_D, 2);
        step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); #1 cmp("alu_age3_sel", op1_byp_sel_D, 3);
        step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); #1 cmp("alu_retired_sel", op1_byp_sel_D, 0);
        cmp("alu_retired_busy", busy, 0);
        // Load-use
        step(1, 0, 0, 0, 0, 1, 7, 2, 0, 0);
        step(1, 0, 0, 1, 7, 0, 0, 0, 0, 0); #1 cmp("lw_stall", stall_D, 1);
        cmp("lw_no_issue", issue_D, 0);
        step(1, 0, 0, 1, 7, 0, 0, 0, 0, 0); #1 cmp("lw_sel2", op2_byp_sel_D, 2);
        // Multi-cycle mul with freeze
        step(1, 0, 0, 0, 0, 1, 9, 3, 0, 0);
        step(1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 9, 0, 0, 0, 0, 0, 0, 1);
        #1 cmp("mul_frozen_stall", stall_D, 1);
        step(1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 9, 1, 9, 0, 0, 0, 0, 0); #1 cmp("mul_sel3", op1_byp_sel_D, 3);
        // WAW youngest wins
        step(1, 0, 0, 0, 0, 1, 4, 1, 0, 0);
        step(1, 0, 0, 0, 0, 1, 4, 2, 0, 0);
        step(1, 1, 4, 0, 0, 0, 0, 0, 0, 0); #1 cmp("waw_stall", stall_D, 1);
        step(1, 1, 4, 0, 0, 0, 0, 0, 0, 0); #1 cmp("waw_sel", op1_byp_sel_D, 2);
        // Squash and x0
        step(1, 0, 0, 0, 0, 1, 6, 1, 1, 0);
        step(1, 1, 6, 0, 0, 0, 0, 0, 0, 0); #1 cmp("squash_sel", op1_byp_sel_D, 0);
        step(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0); #1 cmp("x0_sel", op1_byp_sel_D, 0);
        // Async reset with three writers in flight
        step(1, 0, 0, 0, 0, 1, 1, 3, 0, 0);
        step(1, 0, 0, 0, 0, 1, 2, 3, 0, 0);
        step(1, 0, 0, 0, 0, 1, 3, 3, 0, 0);
        mid_reset();
        // Randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 350) mid_reset();
            else step($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                      $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                      $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 7) == 0,
                      $urandom_range(0, 7) == 0);
        end
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
